// File: rtl/branch_predictor_gshare.sv
// Table of saturating direction counters indexed by PC (bimodal) or PC XOR global history (gshare).
// Keeps a speculative global history that is repaired on mispredict, plus resolved/mispredict counters.
module branch_predictor_gshare #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 6,
  parameter int MODE       = 1,
  parameter int PC_LSB     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  lookup_valid,
  input  logic [31:0]           lookup_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  output logic [HIST_BITS-1:0]  predict_hist,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic [HIST_BITS-1:0]  update_hist,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  output logic [HIST_BITS-1:0]  ghr,
  output logic [31:0]           stat_branches,
  output logic [31:0]           stat_mispredicts
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [CTR_BITS-1:0]   counterTable [DEPTH];
  logic [HIST_BITS-1:0]  ghrReg;
  logic [HIST_BITS-1:0]  ghrNext;
  logic [HIST_BITS-1:0]  repairHist;
  logic [HIST_BITS-1:0]  specHist;
  logic [INDEX_BITS-1:0] baseIdx;
  logic [INDEX_BITS-1:0] histExt;
  logic [INDEX_BITS-1:0] lookupIdx;
  logic [CTR_BITS-1:0]   updCtr;
  logic [CTR_BITS-1:0]   updCtrNext;
  logic [31:0]           branchesReg;
  logic [31:0]           mispredictsReg;
  logic                  unusedBits;

  assign baseIdx = lookup_pc[PC_LSB +: INDEX_BITS];

  always_comb begin
    histExt = '0;
    histExt[HIST_BITS-1:0] = ghrReg;
  end

  generate
    if (MODE == 0) begin : gBimodal
      assign lookupIdx = baseIdx;
    end else begin : gGshare
      assign lookupIdx = baseIdx ^ histExt;
    end

    // A one-bit history is replaced outright rather than shifted.
    if (HIST_BITS == 1) begin : gHistOne
      assign repairHist = update_taken;
      assign specHist   = predict_taken;
    end else begin : gHistShift
      assign repairHist = {update_hist[HIST_BITS-2:0], update_taken};
      assign specHist   = {ghrReg[HIST_BITS-2:0], predict_taken};
    end
  endgenerate

  assign predict_index = lookupIdx;
  assign predict_taken = counterTable[lookupIdx][CTR_BITS-1];
  assign predict_hist  = ghrReg;
  assign ghr           = ghrReg;

  assign stat_branches    = branchesReg;
  assign stat_mispredicts = mispredictsReg;

  // A mispredict means any same-cycle lookup is on the wrong path, so repair wins.
  always_comb begin
    ghrNext = ghrReg;
    if (update_valid && update_mispredict) begin
      ghrNext = repairHist;
    end else if (lookup_valid) begin
      ghrNext = specHist;
    end
  end

  always_comb begin
    updCtr     = counterTable[update_index];
    updCtrNext = updCtr;
    if (update_taken) begin
      if (updCtr != CTR_MAX) updCtrNext = updCtr + 1'b1;
    end else begin
      if (updCtr != '0) updCtrNext = updCtr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        counterTable[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      counterTable[update_index] <= updCtrNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ghrReg         <= '0;
      branchesReg    <= '0;
      mispredictsReg <= '0;
    end else begin
      ghrReg <= ghrNext;
      if (update_valid && (branchesReg != 32'hFFFF_FFFF)) begin
        branchesReg <= branchesReg + 32'd1;
      end
      if (update_valid && update_mispredict && (mispredictsReg != 32'hFFFF_FFFF)) begin
        mispredictsReg <= mispredictsReg + 32'd1;
      end
    end
  end

  assign unusedBits = &{1'b0, lookup_pc, update_hist, histExt};

endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the single-bit-state `branch_predictor` in the `arm` pipeline.
- Provides a table of saturating counters indexed by PC, selectable as bimodal or gshare (PC XOR global history).
- Keeps a speculative global history register and restores it on a mispredict.
- Counts resolved branches and mispredicts for performance analysis.
- Fetch looks up a prediction in the same cycle. Execute sends resolved outcomes back later through the update port.

Parameters:
- INDEX_BITS, 6, log2 of table depth (64 entries); legal range 2..12.
- CTR_BITS, 2, width of each saturating counter; legal range 1..4.
- HIST_BITS, 6, global history length; must be <= INDEX_BITS.
- MODE, 1, index function: 0 = bimodal (PC only), 1 = gshare (PC XOR history).
- PC_LSB, 2, lowest PC bit used in the index (word-aligned fetch).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- lookup_valid, input, 1, fetch is presenting a branch PC this cycle.
- lookup_pc, input, 32, fetch PC.
- predict_taken, output, 1, prediction for lookup_pc (combinational).
- predict_index, output, INDEX_BITS, table index used; travels down the pipe with the branch.
- predict_hist, output, HIST_BITS, history snapshot before this lookup; travels with the branch.
- update_valid, input, 1, execute has resolved a branch.
- update_index, input, INDEX_BITS, the predict_index that came with that branch.
- update_hist, input, HIST_BITS, the predict_hist that came with that branch.
- update_taken, input, 1, actual outcome.
- update_mispredict, input, 1, predicted direction was wrong.
- ghr, output, HIST_BITS, current speculative global history (debug).
- stat_branches, output, 32, resolved branch count.
- stat_mispredicts, output, 32, mispredict count.

Behaviour:
- Reset (reset=0, asynchronous):
  - every counter = 2^(CTR_BITS-1)-1, i.e. weakly not-taken (1 for 2-bit counters);
  - ghr = 0; both stat counters = 0.
  - predict_taken, predict_index and predict_hist follow their combinational definitions from reset state.
  - Reset asserted mid-operation discards every pending update in that cycle.
- Index:
  - base = lookup_pc[PC_LSB+INDEX_BITS-1:PC_LSB].
  - MODE=0: index = base.
  - MODE=1: index = base XOR {zero-extend(ghr) to INDEX_BITS}.
- Lookup:
  - purely combinational; zero-cycle latency.
  - predict_taken = MSB of table[index]; predict_hist = ghr.
  - Outputs are valid even when lookup_valid=0, but have no side effects then.
- Speculative history, evaluated each clock edge in priority order:
  1. update_valid & update_mispredict: ghr <= {update_hist[HIST_BITS-2:0], update_taken}. This repairs the history. Any same-cycle lookup is discarded because it is on the wrong path.
  2. else if lookup_valid: ghr <= {ghr[HIST_BITS-2:0], predict_taken}.
  3. else ghr holds.
  - When HIST_BITS=1, the shifted-in bit is the whole register.
- Counter update, on the edge when update_valid=1:
  - update_taken=1: table[update_index] increments, saturating at 2^CTR_BITS-1.
  - update_taken=0: it decrements, saturating at 0.
  - Exactly one entry changes per cycle.
- Same-index lookup and update in one cycle: the lookup returns the pre-update value. There is no bypass.
- Statistics:
  - update_valid increments stat_branches.
  - update_valid & update_mispredict also increments stat_mispredicts.
  - Both counters saturate at 32'hFFFF_FFFF; they do not wrap.
- No handshake back-pressure: the block accepts one lookup and one update every cycle.
- update_mispredict is ignored when update_valid=0.
- Storage is a register array, so the asynchronous reset is legal; no SRAM macro is used.

Test Plan:
- Reset check: defaults, reset=0 then 1 → ghr=0, stats=0; lookup_pc=0x0000_0040 gives predict_index=0x10 and predict_taken=0.
- Saturation, MODE=0: four updates index=5, taken=1 → entry 5 = 3 and predict_taken=1. Five further updates taken=0 → entry stays 0 (no underflow) and predict_taken=0.
- Gshare hashing, MODE=1: ghr=6'b101010, lookup_pc=0x0000_0100 (base 0x00) → predict_index=0x2A. With predict_taken=0, the next ghr = 6'b010100.
- Mispredict repair: lookup and mispredict in the same cycle with update_hist=6'b000111, update_taken=1 → ghr=6'b001111 and the lookup shift is dropped.
- Same-index hazard: entry 3 = 1; lookup index 3 and update index 3 taken=1 in one cycle → predict_taken=0 that cycle, then 1 on the next cycle.
- Stats and async reset: 10 updates including 3 mispredicts → stat_branches=10, stat_mispredicts=3. Pulsing reset low between clock edges clears both immediately, without waiting for a clock edge.
